uart_tx_scheduler: RTL and testbench

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_fifo.sv | 60 ++++++
 rtl/uart_tx_scheduler.sv | 145 ++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
package uart_pkg;

  localparam int unsigned DATA_W           = 8;
  localparam int unsigned FIFO_DEPTH_DEF   = 4;
  localparam int unsigned BUSY_TIMEOUT_DEF = 16384;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_DONE = 2'd2
  } sched_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Per-requester byte FIFO with occupancy count. A freshly written entry
// becomes readable one cycle after its write, so the head is never read
// from a storage slot in the same cycle it was written.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_valid,
  input  logic [DATA_W-1:0]            wr_data,
  output logic                         wr_ready_c,
  input  logic                         rd_pop,
  output logic [DATA_W-1:0]            rd_data_c,
  output logic                         rd_avail_c,
  output logic [$clog2(DEPTH):0]       level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_d;
  logic              push_ok;
  logic              pop_ok;

  assign wr_ready_c = (level != LW'(DEPTH));
  assign rd_avail_c = (level > LW'(push_d));
  assign rd_data_c  = mem[rd_ptr];
  assign push_ok    = wr_valid && wr_ready_c;
  assign pop_ok     = rd_pop && rd_avail_c;

  // Storage write; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and write-visibility delay.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      push_d <= 1'b0;
    end else begin
      push_d <= push_ok;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Two-requester round-robin scheduler feeding a single UART transmitter
// through a start/busy handshake with a launch timeout.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int unsigned BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_valid0,
  input  logic [DATA_W-1:0]             i_data0,
  output logic                          o_ready0,
  input  logic                          i_valid1,
  input  logic [DATA_W-1:0]             i_data1,
  output logic                          o_ready1,
  output logic                          o_tx_start,
  output logic [DATA_W-1:0]             o_tx_data,
  input  logic                          i_tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_level0,
  output logic [$clog2(FIFO_DEPTH):0]   o_level1,
  output logic                          o_timeout_err,
  input  logic                          i_clear_err
);

  localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BUSY_TIMEOUT);

  sched_state_e      state, state_n;
  logic              busy_meta, busy_s;
  logic              last_grant, last_grant_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              start_n;
  logic [DATA_W-1:0] data_n;
  logic              err_n;
  logic              pop0_c, pop1_c;
  logic              avail0_c, avail1_c;
  logic [DATA_W-1:0] head0_c, head1_c;
  logic              pick_c;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (i_valid0),
    .wr_data    (i_data0),
    .wr_ready_c (o_ready0),
    .rd_pop     (pop0_c),
    .rd_data_c  (head0_c),
    .rd_avail_c (avail0_c),
    .level      (o_level0)
  );

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (i_valid1),
    .wr_data    (i_data1),
    .wr_ready_c (o_ready1),
    .rd_pop     (pop1_c),
    .rd_data_c  (head1_c),
    .rd_avail_c (avail1_c),
    .level      (o_level1)
  );

  // Bring the baud-domain busy flag into clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_meta <= 1'b0;
      busy_s    <= 1'b0;
    end else begin
      busy_meta <= i_tx_busy;
      busy_s    <= busy_meta;
    end
  end

  // State, arbitration history, timeout counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      last_grant    <= 1'b1;
      cnt           <= '0;
      o_tx_start    <= 1'b0;
      o_tx_data     <= '0;
      o_timeout_err <= 1'b0;
    end else begin
      state         <= state_n;
      last_grant    <= last_grant_n;
      cnt           <= cnt_n;
      o_tx_start    <= start_n;
      o_tx_data     <= data_n;
      o_timeout_err <= err_n;
    end
  end

  // Round-robin pick when both heads are ready, otherwise whichever is.
  assign pick_c = (avail0_c && avail1_c) ? ~last_grant : avail1_c;

  // Next-state, pop and launch decisions.
  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    cnt_n        = cnt;
    start_n      = o_tx_start;
    data_n       = o_tx_data;
    err_n        = o_timeout_err && !i_clear_err;
    pop0_c       = 1'b0;
    pop1_c       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!busy_s && (avail0_c || avail1_c)) begin
          if (pick_c) begin
            pop1_c = 1'b1;
            data_n = head1_c;
          end else begin
            pop0_c = 1'b1;
            data_n = head0_c;
          end
          last_grant_n = pick_c;
          start_n      = 1'b1;
          cnt_n        = '0;
          state_n      = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (busy_s) begin
          start_n = 1'b0;
          state_n = ST_WAIT_DONE;
        end else if (cnt == CNT_LAST) begin
          start_n = 1'b0;
          err_n   = 1'b1;
          state_n = ST_IDLE;
        end else if (cnt != CNT_MAX) begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!busy_s) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for the UART transmit scheduler.
module tb_uart_tx_scheduler;

  localparam int unsigned T_OUT = 16384;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_valid0, i_valid1;
  logic [7:0] i_data0, i_data1;
  logic       o_ready0, o_ready1;
  logic       o_tx_start;
  logic [7:0] o_tx_data;
  logic       i_tx_busy;
  logic [2:0] o_level0, o_level1;
  logic       o_timeout_err;
  logic       i_clear_err;

  int vectors     = 0;
  int miscompares = 0;

  uart_tx_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .i_valid0      (i_valid0),
    .i_data0       (i_data0),
    .o_ready0      (o_ready0),
    .i_valid1      (i_valid1),
    .i_data1       (i_data1),
    .o_ready1      (o_ready1),
    .o_tx_start    (o_tx_start),
    .o_tx_data     (o_tx_data),
    .i_tx_busy     (i_tx_busy),
    .o_level0      (o_level0),
    .o_level1      (o_level1),
    .o_timeout_err (o_timeout_err),
    .i_clear_err   (i_clear_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    tick();
    reset = 1'b0;
  endtask

  // Wait (bounded) for a launch, check its byte, then model the busy pulse.
  task automatic serve(input string tag, input logic [7:0] exp);
    int n = 0;
    while (!o_tx_start && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_start"}, 32'(o_tx_start), 32'd1);
    chk({tag, "_data"}, 32'(o_tx_data), 32'(exp));
    i_tx_busy = 1'b1;
    repeat (3) tick();
    chk({tag, "_fall"}, 32'(o_tx_start), 32'd0);
    i_tx_busy = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    reset = 1'b1; i_valid0 = 0; i_valid1 = 0; i_data0 = 0; i_data1 = 0;
    i_tx_busy = 0; i_clear_err = 0;
    tick();
    chk("rst_level0", 32'(o_level0), 32'd0);
    chk("rst_level1", 32'(o_level1), 32'd0);
    chk("rst_ready0", 32'(o_ready0), 32'd1);
    chk("rst_ready1", 32'(o_ready1), 32'd1);
    chk("rst_start",  32'(o_tx_start), 32'd0);
    chk("rst_data",   32'(o_tx_data), 32'd0);
    chk("rst_err",    32'(o_timeout_err), 32'd0);
    reset = 1'b0;
    tick();

    // Single byte: latency of two edges, held for 100 cycles, busy handshake.
    i_valid0 = 1; i_data0 = 8'h41;
    tick();
    i_valid0 = 0;
    chk("lat_n_level", 32'(o_level0), 32'd1);
    chk("lat_n_start", 32'(o_tx_start), 32'd0);
    tick();
    chk("lat_n1_start", 32'(o_tx_start), 32'd0);
    tick();
    chk("lat_n2_start", 32'(o_tx_start), 32'd1);
    chk("lat_n2_data",  32'(o_tx_data), 32'h41);
    chk("lat_n2_level", 32'(o_level0), 32'd0);
    repeat (100) tick();
    chk("hold_start", 32'(o_tx_start), 32'd1);
    chk("hold_data",  32'(o_tx_data), 32'h41);
    i_tx_busy = 1;
    repeat (2) tick();
    chk("busy2_start", 32'(o_tx_start), 32'd1);
    tick();
    chk("busy3_start", 32'(o_tx_start), 32'd0);
    i_tx_busy = 0;
    repeat (3) tick();
    chk("done_start", 32'(o_tx_start), 32'd0);

    // Round robin: contention after reset goes to port 0 first.
    do_reset();
    i_valid0 = 1; i_valid1 = 1; i_data0 = 8'h10; i_data1 = 8'h20;
    tick();
    i_data0 = 8'h11; i_data1 = 8'h21;
    tick();
    i_valid0 = 0; i_valid1 = 0;
    chk("rr_level0", 32'(o_level0), 32'd2);
    chk("rr_level1", 32'(o_level1), 32'd2);
    serve("rr_b0", 8'h10);
    serve("rr_b1", 8'h20);
    serve("rr_b2", 8'h11);
    serve("rr_b3", 8'h21);
    chk("rr_empty0", 32'(o_level0), 32'd0);
    chk("rr_empty1", 32'(o_level1), 32'd0);

    // Fill port 0 while the transmitter is busy; fifth push is refused.
    do_reset();
    i_tx_busy = 1;
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      i_valid0 = 1; i_data0 = 8'(8'h30 + i);
      tick();
      chk($sformatf("full_level_%0d", i), 32'(o_level0), (i < 3) ? 32'(i + 1) : 32'd4);
      chk($sformatf("full_ready_%0d", i), 32'(o_ready0), (i < 3) ? 32'd1 : 32'd0);
    end
    i_valid0 = 0;
    tick();
    chk("full_level_end", 32'(o_level0), 32'd4);
    chk("full_no_start",  32'(o_tx_start), 32'd0);
    i_tx_busy = 0;

    // Launch timeout with busy never rising; byte is dropped.
    do_reset();
    i_valid1 = 1; i_data1 = 8'h55;
    tick();
    i_valid1 = 0;
    repeat (2) tick();
    chk("to_launch", 32'(o_tx_start), 32'd1);
    repeat (T_OUT - 1) tick();
    chk("to_pre_start", 32'(o_tx_start), 32'd1);
    chk("to_pre_err",   32'(o_timeout_err), 32'd0);
    tick();
    chk("to_start", 32'(o_tx_start), 32'd0);
    chk("to_err",   32'(o_timeout_err), 32'd1);
    repeat (5) tick();
    chk("to_dropped", 32'(o_tx_start), 32'd0);
    chk("to_sticky",  32'(o_timeout_err), 32'd1);
    i_clear_err = 1;
    tick();
    i_clear_err = 0;
    chk("to_clear", 32'(o_timeout_err), 32'd0);

    // Reset during WAIT_DONE with three bytes queued.
    do_reset();
    i_valid0 = 1; i_data0 = 8'h61;
    tick();
    i_valid0 = 0;
    repeat (2) tick();
    chk("rw_launch", 32'(o_tx_start), 32'd1);
    i_tx_busy = 1;
    repeat (3) tick();
    chk("rw_wait", 32'(o_tx_start), 32'd0);
    for (int i = 0; i < 3; i++) begin
      i_valid0 = 1; i_data0 = 8'(8'h62 + i);
      tick();
    end
    i_valid0 = 0;
    chk("rw_queued", 32'(o_level0), 32'd3);
    #2 reset = 1'b1;
    #1;
    chk("rw_level0", 32'(o_level0), 32'd0);
    chk("rw_ready0", 32'(o_ready0), 32'd1);
    chk("rw_start",  32'(o_tx_start), 32'd0);
    i_tx_busy = 0;
    tick();
    reset = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (o_tx_start) seen++;
      end
      chk("rw_no_launch", 32'(seen), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
